// File: rtl/retro_sram_arbiter.sv
// Round-robin arbiter that shares one single-port asynchronous SRAM bus between
// several initiators. Every SRAM-side output is registered and has a programmable wait-state count.
module retro_sram_arbiter #(
  parameter int Requesters      = 4,
  parameter int AddressBusWidth = 16,
  parameter int DataBusWidth    = 1,
  parameter int WaitStates      = 1
) (
  input  logic                                    Clk,
  input  logic                                    NReset,
  input  logic [Requesters-1:0]                   ReqAccess,
  input  logic [Requesters-1:0]                   ReqWrite,
  input  logic [Requesters*AddressBusWidth-1:0]   ReqAddress,
  input  logic [Requesters*8*DataBusWidth-1:0]    ReqDin,
  output logic [Requesters-1:0]                   ReqReady,
  output logic [Requesters-1:0]                   ReqDataReady,
  output logic [8*DataBusWidth-1:0]               ReqDout,
  output logic                                    MemAccess,
  output logic                                    MemWrite,
  output logic [AddressBusWidth-1:0]              MemAddress,
  output logic [8*DataBusWidth-1:0]               MemDout,
  input  logic [8*DataBusWidth-1:0]               MemDin
);

  localparam int AW = AddressBusWidth;
  localparam int DW = 8 * DataBusWidth;
  localparam int IW = (Requesters > 1) ? $clog2(Requesters) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                          r_state, w_state_nxt;
  logic [3:0]                      r_cnt, w_cnt_nxt;
  logic [IW-1:0]                   r_ptr, w_ptr_nxt;
  logic [IW-1:0]                   r_gnt, w_gnt_nxt;
  logic [Requesters-1:0]           w_rdy_nxt, w_drdy_nxt;
  logic [DW-1:0]                   w_dout_nxt, w_mdout_nxt;
  logic                            w_macc_nxt, w_mwr_nxt;
  logic [AW-1:0]                   w_maddr_nxt;

  logic [Requesters-1:0][AW-1:0]   w_addr;
  logic [Requesters-1:0][DW-1:0]   w_din;
  logic                            w_found;
  logic [IW-1:0]                   w_win;

  for (genvar i = 0; i < Requesters; i++) begin : g_unpack
    assign w_addr[i] = ReqAddress[i*AW +: AW];
    assign w_din[i]  = ReqDin[i*DW +: DW];
  end

  // First requester at or above the pointer, wrapping at Requesters.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < Requesters; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= Requesters) idx = idx - Requesters;
      if (!w_found && ReqAccess[idx]) begin
        w_found = 1'b1;
        w_win   = IW'(idx);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt;
    w_rdy_nxt   = '0;
    w_drdy_nxt  = '0;
    w_dout_nxt  = ReqDout;
    w_macc_nxt  = MemAccess;
    w_mwr_nxt   = MemWrite;
    w_maddr_nxt = MemAddress;
    w_mdout_nxt = MemDout;
    case (r_state)
      IDLE: begin
        w_macc_nxt = 1'b0;
        w_mwr_nxt  = 1'b0;
        if (w_found) begin
          w_maddr_nxt      = w_addr[w_win];
          w_mdout_nxt      = w_din[w_win];
          w_macc_nxt       = 1'b1;
          w_mwr_nxt        = ReqWrite[w_win];
          w_cnt_nxt        = 4'(WaitStates);
          w_gnt_nxt        = w_win;
          w_rdy_nxt[w_win] = 1'b1;
          w_ptr_nxt        = (w_win == IW'(Requesters - 1)) ? '0 : w_win + 1'b1;
          w_state_nxt      = ACCESS;
        end
      end
      ACCESS: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          // Last window cycle: sample read data while the bus is still driven.
          if (!MemWrite) begin
            w_dout_nxt        = MemDin;
            w_drdy_nxt[r_gnt] = 1'b1;
          end
          w_macc_nxt  = 1'b0;
          w_mwr_nxt   = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge NReset) begin
    if (!NReset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_ptr        <= '0;
      r_gnt        <= '0;
      ReqReady     <= '0;
      ReqDataReady <= '0;
      ReqDout      <= '0;
      MemAccess    <= 1'b0;
      MemWrite     <= 1'b0;
      MemAddress   <= '0;
      MemDout      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_ptr        <= w_ptr_nxt;
      r_gnt        <= w_gnt_nxt;
      ReqReady     <= w_rdy_nxt;
      ReqDataReady <= w_drdy_nxt;
      ReqDout      <= w_dout_nxt;
      MemAccess    <= w_macc_nxt;
      MemWrite     <= w_mwr_nxt;
      MemAddress   <= w_maddr_nxt;
      MemDout      <= w_mdout_nxt;
    end
  end

endmodule
